// File: rtl/conf_split_2.sv
// Clocked two-way split for the drive/free token protocol: steers each upstream token to one of two
// branches and merges the branch frees back into one upstream free stream. Optional stats: CONF_SPLIT_2_STAT_EN.
module conf_split_2 #(
    parameter int MAX_OUT = 4
`ifdef CONF_SPLIT_2_STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_drive,
    input  logic i_sel,
    output logic o_free,
    output logic o_ready0,
    output logic o_ready1,
    output logic o_drive0,
    input  logic i_free0,
    output logic o_drive1,
    input  logic i_free1,
    output logic o_err
`ifdef CONF_SPLIT_2_STAT_EN
    ,
    output logic [CNT_W-1:0] o_tok0,
    output logic [CNT_W-1:0] o_tok1,
    output logic [CNT_W-1:0] o_rej
`endif
);

    // Counts fit 8 bits for MAX_OUT <= 255; pend holds at most 2*MAX_OUT.
    localparam logic [7:0] MAX_C = 8'(MAX_OUT);

    typedef enum logic {
        IDLE,
        EMIT
    } emit_state_t;

    emit_state_t state, state_next;
    logic [7:0]  cnt0, cnt1, cnt0_next, cnt1_next;
    logic [9:0]  pend, pend_next;
    logic        acc0, acc1, rej, fr0, fr1, bad0, bad1;

    // Accept decisions use the registered ready, so a same-cycle free cannot rescue a full branch.
    always_comb begin
        acc0      = i_drive && !i_sel && o_ready0;
        acc1      = i_drive &&  i_sel && o_ready1;
        rej       = i_drive && !(i_sel ? o_ready1 : o_ready0);
        fr0       = i_free0 && (cnt0 != 8'd0);
        fr1       = i_free1 && (cnt1 != 8'd0);
        bad0      = i_free0 && (cnt0 == 8'd0);
        bad1      = i_free1 && (cnt1 == 8'd0);
        cnt0_next = cnt0 + {7'd0, acc0} - {7'd0, fr0};
        cnt1_next = cnt1 + {7'd0, acc1} - {7'd0, fr1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0     <= 8'd0;
            cnt1     <= 8'd0;
            o_ready0 <= 1'b1;
            o_ready1 <= 1'b1;
            o_drive0 <= 1'b0;
            o_drive1 <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            cnt0     <= cnt0_next;
            cnt1     <= cnt1_next;
            o_ready0 <= (cnt0_next < MAX_C);
            o_ready1 <= (cnt1_next < MAX_C);
            o_drive0 <= acc0;
            o_drive1 <= acc1;
            o_err    <= o_err || rej || bad0 || bad1;
        end
    end

    // Free emitter: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 10'd0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
        end
    end

    // Each EMIT cycle retires one pending token while new arrivals are folded in.
    always_comb begin
        pend_next  = pend + {9'd0, fr0} + {9'd0, fr1} - {9'd0, (state == EMIT)};
        state_next = (pend_next != 10'd0) ? EMIT : IDLE;
    end

    always_comb begin
        o_free = (state == EMIT);
    end

`ifdef CONF_SPLIT_2_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tok0 <= '0;
            o_tok1 <= '0;
            o_rej  <= '0;
        end else begin
            if (acc0) o_tok0 <= o_tok0 + 1'b1;
            if (acc1) o_tok1 <= o_tok1 + 1'b1;
            if (rej && (o_rej != {CNT_W{1'b1}})) o_rej <= o_rej + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conf_split_2.sv
// Directed self-checking bench for conf_split_2 (MAX_OUT = 4); stats ports checked when CONF_SPLIT_2_STAT_EN is defined.
module tb_conf_split_2;

    logic clk = 1'b0;
    logic rst, i_drive, i_sel, i_free0, i_free1;
    logic o_free, o_ready0, o_ready1, o_drive0, o_drive1, o_err;
`ifdef CONF_SPLIT_2_STAT_EN
    logic [15:0] o_tok0, o_tok1, o_rej;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conf_split_2 #(.MAX_OUT(4)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_sel(i_sel),
        .o_free(o_free), .o_ready0(o_ready0), .o_ready1(o_ready1),
        .o_drive0(o_drive0), .i_free0(i_free0),
        .o_drive1(o_drive1), .i_free1(i_free1), .o_err(o_err)
`ifdef CONF_SPLIT_2_STAT_EN
        , .o_tok0(o_tok0), .o_tok1(o_tok1), .o_rej(o_rej)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic d, input logic s, input logic f0, input logic f1);
        i_drive = d;
        i_sel   = s;
        i_free0 = f0;
        i_free1 = f1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        tick();
        tick();
        checks++;
        if ({o_ready0, o_ready1, o_drive0, o_drive1, o_free, o_err} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected 110000", {o_ready0, o_ready1, o_drive0, o_drive1, o_free, o_err});
        end
`ifdef CONF_SPLIT_2_STAT_EN
        checks++;
        if ({o_tok0, o_tok1, o_rej} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got %h expected 0", {o_tok0, o_tok1, o_rej});
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_in(1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if ({o_drive0, o_drive1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_drive: got %b expected 10", {o_drive0, o_drive1});
        end
        tick();
        checks++;
        if ({o_drive0, o_drive1} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_drive_end: got %b expected 00", {o_drive0, o_drive1});
        end
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (o_free !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_free: got %b expected 1", o_free);
        end
        tick();
        checks++;
        if ({o_free, o_err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_free_end: got %b expected 00", {o_free, o_err});
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_in(1, 1, 0, 0);
            tick();
            checks++;
            if ({o_drive1, o_ready1, o_err, o_ready0} !== {(k <= 4), (k < 4), (k == 5), 1'b1}) begin
                errors++;
                $display("[TB] FAIL fill_step%0d: got %b expected %b", k, {o_drive1, o_ready1, o_err, o_ready0},
                         {(k <= 4), (k < 4), (k == 5), 1'b1});
            end
        end
        set_in(0, 0, 0, 0);
`ifdef CONF_SPLIT_2_STAT_EN
        checks++;
        if ({o_tok0, o_tok1, o_rej} !== {16'd0, 16'd4, 16'd1}) begin
            errors++;
            $display("[TB] FAIL fill_stats: got %h expected 000000040001", {o_tok0, o_tok1, o_rej});
        end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1, 0, 0, 0);
        tick();
        checks++;
        if ({o_drive0, o_drive1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_1: got %b expected 10", {o_drive0, o_drive1});
        end
        set_in(1, 1, 0, 0);
        tick();
        checks++;
        if ({o_drive0, o_drive1} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_2: got %b expected 01", {o_drive0, o_drive1});
        end
        set_in(1, 0, 0, 0);
        tick();
        checks++;
        if ({o_drive0, o_drive1} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_3: got %b expected 10", {o_drive0, o_drive1});
        end
        set_in(0, 0, 0, 0);
        tick();
        checks++;
        if ({o_drive0, o_drive1, o_err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL b2b_end: got %b expected 000", {o_drive0, o_drive1, o_err});
        end
    endtask

    task automatic test_dual_free();
        do_reset();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 1, 0, 0); tick();
        set_in(1, 1, 0, 0); tick();
        set_in(0, 0, 0, 0); tick();
        set_in(0, 0, 1, 1);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (o_free !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dual_free_t1: got %b expected 1", o_free);
        end
        tick();
        checks++;
        if (o_free !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dual_free_t2: got %b expected 1", o_free);
        end
        tick();
        checks++;
        if (o_free !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dual_free_t3: got %b expected 0", o_free);
        end
        // One token left per branch: each frees cleanly once, a third free0 is an error.
        set_in(0, 0, 1, 0); tick();
        set_in(0, 0, 0, 1); tick();
        checks++;
        if ({o_free, o_err} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL dual_free_rest: got %b expected 10", {o_free, o_err});
        end
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if ({o_free, o_err} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL dual_free_extra: got %b expected 01", {o_free, o_err});
        end
    endtask

    task automatic test_bad_free();
        do_reset();
        set_in(0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if ({o_free, o_err} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bad_free: got %b expected 01", {o_free, o_err});
        end
        set_in(1, 0, 0, 0); tick();
        set_in(0, 0, 0, 0); tick(); tick();
        checks++;
        if ({o_free, o_err} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bad_free_sticky: got %b expected 01", {o_free, o_err});
        end
    endtask

    task automatic test_full_collision();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 0, 0);
            tick();
        end
        checks++;
        if ({o_ready0, o_err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL full_ready0: got %b expected 00", {o_ready0, o_err});
        end
        set_in(1, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if ({o_drive0, o_err, o_free, o_ready0} !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL full_collision: got %b expected 0111", {o_drive0, o_err, o_free, o_ready0});
        end
        tick();
        checks++;
        if ({o_free, o_ready0} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL full_collision_end: got %b expected 01", {o_free, o_ready0});
        end
    endtask

    task automatic test_accept_free_same();
        do_reset();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if ({o_drive0, o_free, o_err} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL same_branch: got %b expected 110", {o_drive0, o_free, o_err});
        end
        set_in(0, 0, 1, 0); tick();
        checks++;
        if ({o_free, o_err} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL same_branch_last: got %b expected 10", {o_free, o_err});
        end
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL same_branch_extra: got %b expected 1", o_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 0, 0, 0); tick();
        set_in(1, 1, 0, 0); tick();
        set_in(0, 0, 1, 1); tick();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({o_ready0, o_ready1, o_drive0, o_drive1, o_free, o_err} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL midflight_reset: got %b expected 110000", {o_ready0, o_ready1, o_drive0, o_drive1, o_free, o_err});
        end
`ifdef CONF_SPLIT_2_STAT_EN
        checks++;
        if ({o_tok0, o_tok1, o_rej} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL midflight_stats: got %h expected 0", {o_tok0, o_tok1, o_rej});
        end
`endif
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (o_free !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midflight_nofree%0d: got %b expected 0", k, o_free);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_dual_free();
        test_bad_free();
        test_full_collision();
        test_accept_free_same();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_split_2.md
Name: conf_split_2

Overview:
- Clocked two-way split for the drive/free token protocol; the counterpart of the two-input mutex merge.
- One upstream drive/free channel is steered, token by token, to one of two downstream branches according to a select bit.
- Each downstream free is returned upstream as a single free, so upstream sees exactly one free per accepted drive.
- Sits where one token source feeds two exclusive consumers in the clocked control fabric.

Parameters:
- MAX_OUT, 4, maximum outstanding (driven, not yet freed) tokens per branch; legal range 1..255.
- CNT_W, 16, width of the per-branch statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- i_drive  input  1  upstream drive; single-cycle pulse, one token per high cycle.
- i_sel  input  1  branch select, sampled with i_drive (0 = branch 0, 1 = branch 1).
- o_free  output  1  upstream free; single-cycle pulse, one per returned token.
- o_ready0  output  1  branch 0 can accept a token (registered).
- o_ready1  output  1  branch 1 can accept a token (registered).
- o_drive0  output  1  branch 0 drive pulse.
- i_free0  input  1  branch 0 free pulse.
- o_drive1  output  1  branch 1 drive pulse.
- i_free1  input  1  branch 1 free pulse.
- o_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs 0 except o_ready0 = o_ready1 = 1.
- Reset also clears internal state: cnt0 = cnt1 = 0, pend = 0, and the error flag.
- Reset wins over every other event in the same cycle; pending frees and outstanding counts are discarded.
- cntB is the outstanding token count for branch B, range 0..MAX_OUT. o_readyB = (cntB < MAX_OUT), registered, so it reflects the count at the start of the cycle.
- Accept: if i_drive = 1 and o_ready[i_sel] = 1 at edge t, then o_drive[i_sel] = 1 during cycle t+1 only, and cnt[i_sel] increments (visible at t+1). Latency is 1 cycle; back-to-back accepts give back-to-back pulses.
- Reject: i_drive = 1 with o_ready[i_sel] = 0 drops the token (no drive, no count change) and sets o_err.
- Free return: i_freeB = 1 with cntB > 0 decrements cntB and increments pend. i_freeB = 1 with cntB = 0 is ignored and sets o_err.
- Free emitter has two states:
  - IDLE: o_free = 0; moves to EMIT when pend > 0 next cycle.
  - EMIT: o_free = 1 for one cycle per token; pend decrements each cycle; stays in EMIT while pend after decrement, plus new arrivals, is > 0.
  - Net effect: a single isolated free appears on o_free 1 cycle after i_freeB, and o_free is never high for more tokens than were freed.
- Simultaneous events:
  - Accept and free on the same branch in the same cycle: count unchanged; both pulses still produced.
  - i_free0 and i_free1 in the same cycle: pend += 2; o_free pulses on two consecutive cycles.
  - Accept into branch B while cntB = MAX_OUT and i_freeB = 1 in the same cycle: rejected, because ready is registered; o_err is set.
- pend width is sized for 2*MAX_OUT, so it never overflows under legal traffic.
- o_err clears only on rst.

Optional Feature:
- Macro: CONF_SPLIT_2_STAT_EN.
- When defined:
  - Adds output ports o_tok0 and o_tok1 (CNT_W bits each), counting accepted tokens per branch.
  - Counters increment at the same edge as cntB, wrap modulo 2^CNT_W, and reset to 0.
  - Adds o_rej (CNT_W bits), counting rejected drives, saturating at all-ones.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then i_drive with i_sel = 0 at cycle 5 -> o_drive0 high at cycle 6 only, o_drive1 stays 0; i_free0 at cycle 10 -> o_free high at cycle 11 only, o_err = 0.
- MAX_OUT = 4: five consecutive drives with i_sel = 1 -> four o_drive1 pulses; o_ready1 = 0 after the fourth; the fifth is dropped and o_err = 1; o_ready0 stays 1.
- Two outstanding tokens per branch; i_free0 and i_free1 asserted in the same cycle t -> o_free high at t+1 and t+2, then 0; cnt0 = cnt1 = 1.
- i_free1 with cnt1 = 0 -> no o_free; o_err = 1, and it stays 1 until rst.
- Branch 0 full; assert i_drive(sel 0) and i_free0 together -> drive rejected, o_err = 1, one o_free pulse; next cycle o_ready0 = 1.
- Three tokens outstanding and two frees pending; assert rst -> next cycle all outputs 0, o_ready0/1 = 1, and no further o_free pulses. With CONF_SPLIT_2_STAT_EN defined: o_tok0/o_tok1/o_rej = 0.
